// File: rtl/amp_seq_if.sv
// Sequencer-side bundle: sample strobe, EQ status, volume target and mute request in;
// CODEC reset, amp enable, volume and run status out.
interface amp_seq_if;
    logic        valid;
    logic        sequencing;
    logic [12:0] volume_in;
    logic        mute_req;
    logic        codec_rst_n;
    logic        amp_on;
    logic [12:0] vol_out;
    logic        running;

    modport master (
        output valid, sequencing, volume_in, mute_req,
        input  codec_rst_n, amp_on, vol_out, running
    );

    modport slave (
        input  valid, sequencing, volume_in, mute_req,
        output codec_rst_n, amp_on, vol_out, running
    );
endinterface

// File: rtl/amp_startup_seq.sv
// Power-up/down sequencer: CODEC reset hold, EQ fill wait, amp warm-up, pop-free volume ramp.
// Build option SOFT_RAMP_EN: ramp/mute in RAMP_STEP increments; otherwise volume jumps.
module amp_startup_seq #(
    parameter int RST_CYC      = 1024,
    parameter int SETTLE_SMPLS = 8,
    parameter int AMP_DLY      = 64,
    parameter int RAMP_STEP    = 16
) (
    input logic    clk,
    input logic    rst_n,
    amp_seq_if.slave bus
);

    localparam int CMAX = (RST_CYC > AMP_DLY)
                        ? ((RST_CYC > SETTLE_SMPLS) ? RST_CYC : SETTLE_SMPLS)
                        : ((AMP_DLY > SETTLE_SMPLS) ? AMP_DLY : SETTLE_SMPLS);
    localparam int CW = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        RST_HOLD,
        WAIT_FILL,
        AMP_WARM,
        RAMP_UP,
        RUN,
        MUTE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [12:0]   vol_q, vol_d;
    logic          codec_q, amp_q, run_q;
    logic [13:0]   up_sum;
    logic [12:0]   up_vol, dn_vol;

    // Ramp arithmetic: widened add so a target near full scale cannot wrap
    always_comb begin
        up_sum  = {1'b0, vol_q} + 14'(RAMP_STEP);
        cnt_inc = cnt_q + CW'(1);
`ifdef SOFT_RAMP_EN
        up_vol  = (up_sum > {1'b0, bus.volume_in}) ? bus.volume_in : up_sum[12:0];
        dn_vol  = (vol_q >= 13'(RAMP_STEP)) ? vol_q - 13'(RAMP_STEP) : 13'd0;
`else
        up_vol  = bus.volume_in;
        dn_vol  = 13'd0;
`endif
    end

    // Next-state and next volume/count; losing sequencing overrides everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vol_d   = vol_q;
        unique case (state_q)
            RST_HOLD: begin
                if (cnt_q == CW'(RST_CYC - 1)) begin
                    state_d = WAIT_FILL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_FILL: begin
                vol_d = '0;
                if (!bus.sequencing) begin
                    cnt_d = '0;
                end else if (bus.valid) begin
                    if (cnt_inc == CW'(SETTLE_SMPLS)) begin
                        state_d = AMP_WARM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            AMP_WARM: begin
                vol_d = '0;
                if (!bus.sequencing) begin
                    state_d = WAIT_FILL;
                    cnt_d   = '0;
                end else if (bus.valid) begin
                    if (cnt_inc == CW'(AMP_DLY)) begin
                        state_d = RAMP_UP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            RAMP_UP: begin
                if (!bus.sequencing) begin
                    state_d = WAIT_FILL;
                    cnt_d   = '0;
                    vol_d   = '0;
                end else if (bus.mute_req) begin
                    state_d = MUTE;
                end else if (bus.valid) begin
                    vol_d = up_vol;
                    if (up_vol == bus.volume_in) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!bus.sequencing) begin
                    state_d = WAIT_FILL;
                    cnt_d   = '0;
                    vol_d   = '0;
                end else if (bus.mute_req) begin
                    state_d = MUTE;
                end else begin
                    vol_d = bus.volume_in;
                end
            end
            MUTE: begin
                if (!bus.sequencing) begin
                    state_d = WAIT_FILL;
                    cnt_d   = '0;
                    vol_d   = '0;
                end else begin
                    if (bus.valid) begin
                        vol_d = dn_vol;
                    end
                    if (vol_d == 13'd0 && !bus.mute_req) begin
                        state_d = RAMP_UP;
                    end
                end
            end
            default: begin
                state_d = RST_HOLD;
                cnt_d   = '0;
                vol_d   = '0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_HOLD;
            cnt_q   <= '0;
            vol_q   <= '0;
            codec_q <= 1'b0;
            amp_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vol_q   <= vol_d;
            codec_q <= (state_d != RST_HOLD);
            amp_q   <= (state_d == AMP_WARM) || (state_d == RAMP_UP)
                    || (state_d == RUN) || (state_d == MUTE);
            run_q   <= (state_d == RUN);
        end
    end

    assign bus.codec_rst_n = codec_q;
    assign bus.amp_on      = amp_q;
    assign bus.vol_out     = vol_q;
    assign bus.running     = run_q;

endmodule

// File: tb/tb_amp_startup_seq.sv
// Directed bench for amp_startup_seq; expectations follow the build's ramp mode.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_amp_startup_seq;

`ifdef SOFT_RAMP_EN
    localparam int STEP = 16;
`else
    localparam int STEP = 8192;
`endif

    logic clk;
    logic rst_n;
    int   n_run;
    int   n_fail;

    amp_seq_if bus ();

    amp_startup_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic vpulse();
        bus.valid = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
        @(negedge clk);
    endtask

    function automatic int up_exp(input int k, input int tgt);
        return (k * STEP > tgt) ? tgt : k * STEP;
    endfunction

    function automatic int dn_exp(input int k, input int from);
        return (from - k * STEP < 0) ? 0 : from - k * STEP;
    endfunction

    task automatic fill_and_warm(input int vol);
        bus.sequencing = 1'b1;
        bus.volume_in  = 13'(vol);
        repeat (7) vpulse();
        check("amp_before_8th", 32'(bus.amp_on), 32'd0);
        vpulse();
        check("amp_after_8th", 32'(bus.amp_on), 32'd1);
        repeat (63) vpulse();
        check("warm_vol0", 32'(bus.vol_out), 32'd0);
        check("warm_not_run", 32'(bus.running), 32'd0);
        vpulse();
        check("ramp_entry_vol0", 32'(bus.vol_out), 32'd0);
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.valid      = 1'b0;
        bus.sequencing = 1'b0;
        bus.volume_in  = '0;
        bus.mute_req   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_codec", 32'(bus.codec_rst_n), 32'd0);
        check("rst_amp", 32'(bus.amp_on), 32'd0);
        check("rst_vol", 32'(bus.vol_out), 32'd0);
        check("rst_run", 32'(bus.running), 32'd0);

        // codec reset release timing
        rst_n = 1'b1;
        repeat (1023) @(negedge clk);
        check("codec_1023", 32'(bus.codec_rst_n), 32'd0);
        @(negedge clk);
        check("codec_1024", 32'(bus.codec_rst_n), 32'd1);
        repeat (3) vpulse();
        check("amp_seq0", 32'(bus.amp_on), 32'd0);

        // fill, warm and ramp to 0x100
        fill_and_warm(256);
        for (int k = 1; k <= 16; k++) begin
            vpulse();
            check("ramp_vol", 32'(bus.vol_out), 32'(up_exp(k, 256)));
            check("ramp_run", 32'(bus.running), 32'(up_exp(k, 256) == 256));
        end
        bus.volume_in = 13'h123;
        @(negedge clk);
        check("run_track", 32'(bus.vol_out), 32'h123);
        bus.volume_in = 13'h100;
        @(negedge clk);

        // mute ramp-down and release
        bus.mute_req = 1'b1;
        @(negedge clk);
        check("mute_not_run", 32'(bus.running), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            vpulse();
            check("mute_vol", 32'(bus.vol_out), 32'(dn_exp(k, 256)));
            check("mute_amp", 32'(bus.amp_on), 32'd1);
        end
        bus.mute_req = 1'b0;
        @(negedge clk);
`ifdef SOFT_RAMP_EN
        for (int k = 1; k <= 8; k++) begin
            vpulse();
            check("reramp_vol", 32'(bus.vol_out), 32'(k * 16));
        end
        bus.volume_in = 13'h40;
        vpulse();
        check("clamp_vol", 32'(bus.vol_out), 32'h40);
        check("clamp_run", 32'(bus.running), 32'd1);
`else
        vpulse();
        check("reramp_jump", 32'(bus.vol_out), 32'h100);
        check("reramp_run", 32'(bus.running), 32'd1);
`endif
        bus.volume_in = 13'h100;
        @(negedge clk);
        check("run_back", 32'(bus.vol_out), 32'h100);

        // sequencing glitch in RUN
        bus.sequencing = 1'b0;
        @(negedge clk);
        bus.sequencing = 1'b1;
        check("drop_vol", 32'(bus.vol_out), 32'd0);
        check("drop_amp", 32'(bus.amp_on), 32'd0);
        check("drop_run", 32'(bus.running), 32'd0);
        fill_and_warm(256);

        // async reset mid-ramp
`ifdef SOFT_RAMP_EN
        repeat (3) vpulse();
        check("pre_rst_vol", 32'(bus.vol_out), 32'd48);
`else
        vpulse();
        check("pre_rst_jump", 32'(bus.vol_out), 32'h100);
`endif
        #2 rst_n = 1'b0;
        #1;
        check("arst_vol", 32'(bus.vol_out), 32'd0);
        check("arst_amp", 32'(bus.amp_on), 32'd0);
        check("arst_codec", 32'(bus.codec_rst_n), 32'd0);
        check("arst_run", 32'(bus.running), 32'd0);
        @(negedge clk);
        bus.sequencing = 1'b0;
        rst_n = 1'b1;
        repeat (1023) @(negedge clk);
        check("re_codec_1023", 32'(bus.codec_rst_n), 32'd0);
        @(negedge clk);
        check("re_codec_1024", 32'(bus.codec_rst_n), 32'd1);

        // zero target: RUN on first ramp valid
        fill_and_warm(0);
        vpulse();
        check("zero_run", 32'(bus.running), 32'd1);
        check("zero_vol", 32'(bus.vol_out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
